// File: rtl/axis_width_down_bytes.sv
// axis_width_down_bytes
//
// Serialises wide AXI-Stream beats from the common-clock FIFO into 8-bit AXI-Stream beats,
// least-significant lane first. Lanes with tkeep=0 are skipped. tlast moves to the last kept
// byte of a tlast beat. A tlast beat with no kept lanes becomes a single null-terminator byte
// (tdata=0, tkeep=0, tlast=1). Packets completed at the output are counted for status.
//
// Ports
//   aclk, aresetn       clock (rising edge), asynchronous active-low reset
//   s_axis_*            wide input stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   m_axis_*            byte output stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   pkt_count           output beats handshaken with tlast=1, wrapping
//   busy                holding register still has bytes (or a null terminator) to send
//
// Output payload registers are recomputed from the next holding-register state every cycle.
// They therefore change only when the holding register changes, which keeps them stable
// through a downstream stall.

module axis_width_down_bytes #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned KEEP_W    = DATA_W / 8,
   parameter int unsigned USER_W    = 1,
   parameter int unsigned PKT_CNT_W = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,

   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [DATA_W-1:0]    s_axis_tdata,
   input  logic [KEEP_W-1:0]    s_axis_tkeep,
   input  logic                 s_axis_tlast,
   input  logic [USER_W-1:0]    s_axis_tuser,

   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic [USER_W-1:0]    m_axis_tuser,

   output logic [PKT_CNT_W-1:0] pkt_count,
   output logic                 busy
);

   localparam logic [KEEP_W-1:0]    KeepOne = KEEP_W'(1);
   localparam logic [PKT_CNT_W-1:0] CntOne  = PKT_CNT_W'(1);

   // Holding register
   logic [DATA_W-1:0] data_q, data_d;
   logic [KEEP_W-1:0] rem_q, rem_d;
   logic              last_q, last_d;
   logic              null_q, null_d;
   logic [USER_W-1:0] user_q, user_d;

   // Output payload registers
   logic [7:0]        out_data_q, out_data_d;
   logic              out_keep_q, out_keep_d;
   logic              out_last_q, out_last_d;
   logic [USER_W-1:0] out_user_q, out_user_d;

   logic [PKT_CNT_W-1:0] cnt_q, cnt_d;

   logic              hold_busy;
   logic              cur_final;
   logic [KEEP_W-1:0] cur_lane;
   logic              in_hs;
   logic              out_hs;

   function automatic logic is_onehot(input logic [KEEP_W-1:0] v);
      return (v != '0) && ((v & (v - KeepOne)) == '0);
   endfunction

   assign hold_busy = (rem_q != '0) || null_q;

   // Isolate the lowest set bit of the remaining-lane mask.
   assign cur_lane  = rem_q & (~rem_q + KeepOne);

   // A pending null terminator is always the final (and only) byte of its beat.
   assign cur_final = null_q || is_onehot(rem_q);

   assign out_hs        = hold_busy && m_axis_tready;
   assign s_axis_tready = aresetn && (!hold_busy || (out_hs && cur_final));
   assign in_hs         = s_axis_tvalid && s_axis_tready;

   // Next holding-register state
   always_comb begin
      data_d = data_q;
      rem_d  = rem_q;
      last_d = last_q;
      null_d = null_q;
      user_d = user_q;

      if (out_hs) begin
         rem_d  = rem_q & ~cur_lane;
         null_d = 1'b0;
      end

      // A new beat only arrives when the holding register is empty or its final byte is
      // leaving this cycle, so loading unconditionally overrides the drain update above.
      if (in_hs) begin
         data_d = s_axis_tdata;
         rem_d  = s_axis_tkeep;
         last_d = s_axis_tlast;
         user_d = s_axis_tuser;
         null_d = (s_axis_tkeep == '0) && s_axis_tlast;
      end
   end

   // Next output payload, taken from the lowest remaining lane of the next holding state
   always_comb begin
      out_data_d = 8'h00;
      out_keep_d = 1'b0;
      out_last_d = 1'b0;
      out_user_d = '0;

      if (null_d) begin
         out_last_d = 1'b1;
         out_user_d = user_d;
      end else if (rem_d != '0) begin
         out_keep_d = 1'b1;
         out_last_d = last_d && is_onehot(rem_d);
         out_user_d = user_d;
         // Descending scan so the lowest set lane is the one that sticks.
         for (int k = int'(KEEP_W) - 1; k >= 0; k--) begin
            if (rem_d[k]) begin
               out_data_d = data_d[8*k +: 8];
            end
         end
      end
   end

   // Packet counter
   always_comb begin
      cnt_d = cnt_q;
      if (out_hs && out_last_q) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_q     <= '0;
         rem_q      <= '0;
         last_q     <= 1'b0;
         null_q     <= 1'b0;
         user_q     <= '0;
         out_data_q <= 8'h00;
         out_keep_q <= 1'b0;
         out_last_q <= 1'b0;
         out_user_q <= '0;
         cnt_q      <= '0;
      end else begin
         data_q     <= data_d;
         rem_q      <= rem_d;
         last_q     <= last_d;
         null_q     <= null_d;
         user_q     <= user_d;
         out_data_q <= out_data_d;
         out_keep_q <= out_keep_d;
         out_last_q <= out_last_d;
         out_user_q <= out_user_d;
         cnt_q      <= cnt_d;
      end
   end

   assign m_axis_tvalid = hold_busy;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tuser  = out_user_q;
   assign pkt_count     = cnt_q;
   assign busy          = hold_busy;

endmodule

// File: tb/tb_axis_width_down_bytes.sv
// Self-checking bench for axis_width_down_bytes: a scoreboard queue of expected output bytes
// is filled as beats are driven and drained by a monitor on the falling edge.

module tb_axis_width_down_bytes;

   localparam int unsigned CntW = 4;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic [31:0]     s_axis_tdata;
   logic [3:0]      s_axis_tkeep;
   logic            s_axis_tlast;
   logic [0:0]      s_axis_tuser;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [7:0]      m_axis_tdata;
   logic            m_axis_tkeep;
   logic            m_axis_tlast;
   logic [0:0]      m_axis_tuser;
   logic [CntW-1:0] pkt_count;
   logic            busy;

   axis_width_down_bytes #(
      .DATA_W    (32),
      .KEEP_W    (4),
      .USER_W    (1),
      .PKT_CNT_W (CntW)
   ) u_dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .pkt_count     (pkt_count),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       last;
      logic       user;
   } obyte_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
      int          n;          // number of data bytes expected
      logic [31:0] exp_bytes;  // expected bytes, first one in bits 7:0
   } vec_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   obyte_t exp_q[$];
   int     out_log[$];
   logic   prev_stall = 1'b0;
   obyte_t prev_out;

   vec_t        vecs[8];
   int          hs_tab[8];
   logic        busy_tab[8];
   int          hs;
   logic        bsy;
   int          rem_cnt;
   logic [6:0]  pat;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor / scoreboard
   always @(negedge aclk) begin
      obyte_t got;
      obyte_t want;
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", {63'd0, m_axis_tvalid}, 64'd1);
            check("stall_payload_held", 64'(got), 64'(prev_out));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, required no output (cycle %0d)",
                        got, cyc);
            end else begin
               want = exp_q.pop_front();
               check("out_byte", 64'(got), 64'(want));
               out_log.push_back(cyc);
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_out   = got;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] eb, input int n, input logic last,
                           input logic user);
      obyte_t b;
      for (int i = 0; i < n; i++) begin
         b = {eb[8*i +: 8], 1'b1, last && (i == n - 1), user};
         exp_q.push_back(b);
      end
      if (n == 0 && last) begin
         b = {8'h00, 1'b0, 1'b1, user};
         exp_q.push_back(b);
      end
   endtask

   // Leaves tvalid high; caller drops it with idle_in() unless another beat follows.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic u, output int hs_cyc, output logic busy_at);
      int n;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      n = 0;
      @(negedge aclk);
      while (!s_axis_tready && n < 200) begin
         @(negedge aclk);
         n++;
      end
      check("in_handshake", {63'd0, s_axis_tready}, 64'd1);
      hs_cyc  = cyc;
      busy_at = busy;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_in();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge aclk);
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
         @(negedge aclk);
         n++;
      end
      check("drain_idle", {63'd0, m_axis_tvalid}, 64'd0);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      vecs[0] = '{32'h03020100, 4'hF,    1'b0, 1'b0, 4, 32'h03020100};
      vecs[1] = '{32'h07060504, 4'hF,    1'b0, 1'b0, 4, 32'h07060504};
      vecs[2] = '{32'h0B0A0908, 4'hF,    1'b1, 1'b0, 4, 32'h0B0A0908};
      vecs[3] = '{32'hDDCCBBAA, 4'b1010, 1'b0, 1'b1, 2, 32'h0000DDBB};
      vecs[4] = '{32'h12345678, 4'b0000, 1'b1, 1'b1, 0, 32'h00000000};
      vecs[5] = '{32'hAABBCCDD, 4'b0000, 1'b0, 1'b0, 0, 32'h00000000};
      vecs[6] = '{32'h87654321, 4'b0100, 1'b1, 1'b0, 1, 32'h00000065};
      vecs[7] = '{32'h99887766, 4'b1001, 1'b1, 1'b1, 2, 32'h00009966};

      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = '0;
      m_axis_tready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      check("rst_m_tkeep", {63'd0, m_axis_tkeep}, 64'd0);
      check("rst_m_tlast", {63'd0, m_axis_tlast}, 64'd0);
      check("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
      aresetn = 1'b1;
      #1;
      check("idle_s_tready", {63'd0, s_axis_tready}, 64'd1);
      tick();
      m_axis_tready = 1'b1;

      // Single beat: four bytes on consecutive cycles, one cycle after acceptance
      out_log.delete();
      push_exp(32'h44332211, 4, 1'b1, 1'b1);
      send_beat(32'h44332211, 4'hF, 1'b1, 1'b1, hs, bsy);
      idle_in();
      drain();
      check("single_nbytes", 64'(out_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("single_timing", 64'(out_log[i]), 64'(hs + 1 + i));
      end
      check("single_pkt_count", 64'(pkt_count), 64'd1);

      // Table: streaming, sparse, null terminator, empty non-last beat, odd keeps
      out_log.delete();
      for (int i = 0; i < 8; i++) begin
         push_exp(vecs[i].exp_bytes, vecs[i].n, vecs[i].last, vecs[i].user);
         send_beat(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user,
                   hs_tab[i], busy_tab[i]);
      end
      idle_in();
      drain();
      for (int i = 0; i < 12; i++) begin
         check("stream_no_bubble", 64'(out_log[i]), 64'(hs_tab[0] + 1 + i));
      end
      check("stream_ready_period_1", 64'(hs_tab[1] - hs_tab[0]), 64'd4);
      check("stream_ready_period_2", 64'(hs_tab[2] - hs_tab[1]), 64'd4);
      check("sparse_two_bytes", 64'(hs_tab[4] - hs_tab[3]), 64'd2);
      check("null_one_cycle", 64'(hs_tab[5] - hs_tab[4]), 64'd1);
      check("empty_beat_ready_next", 64'(hs_tab[6] - hs_tab[5]), 64'd1);
      check("empty_beat_not_busy", {63'd0, busy_tab[6]}, 64'd0);
      check("table_pkt_count", 64'(pkt_count), 64'd5);

      // Backpressure: m_axis_tready pattern 1,0,0,1,1,0,1 across one 4-byte beat
      pat = 7'b1011001;
      push_exp(32'hD4C3B2A1, 4, 1'b1, 1'b0);
      send_beat(32'hD4C3B2A1, 4'hF, 1'b1, 1'b0, hs, bsy);
      idle_in();
      rem_cnt = 4;
      for (int i = 0; i < 7; i++) begin
         m_axis_tready = pat[i];
         #2;
         check("bp_m_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
         check("bp_s_tready", {63'd0, s_axis_tready}, {63'd0, pat[i] && rem_cnt == 1});
         if (pat[i]) rem_cnt--;
         tick();
      end
      m_axis_tready = 1'b1;
      drain();
      check("bp_pkt_count", 64'(pkt_count), 64'd6);

      // Mid-packet reset after two of four bytes
      push_exp(32'h88776655, 4, 1'b1, 1'b0);
      send_beat(32'h88776655, 4'hF, 1'b1, 1'b0, hs, bsy);
      idle_in();
      tick();
      tick();
      check("pre_rst_remaining", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      aresetn = 1'b0;
      #1;
      check("async_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      check("async_rst_busy", {63'd0, busy}, 64'd0);
      check("async_rst_pkt_count", 64'(pkt_count), 64'd0);
      check("async_rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
      tick();
      tick();
      tick();
      aresetn = 1'b1;
      #1;
      check("post_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      tick();
      push_exp(32'h000000EE, 1, 1'b1, 1'b0);
      send_beat(32'h000000EE, 4'h1, 1'b1, 1'b0, hs, bsy);
      idle_in();
      drain();
      check("post_rst_pkt_count", 64'(pkt_count), 64'd1);

      // Counter wrap with a 4-bit counter: 17 single-byte packets
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) begin
         push_exp({24'h000000, 8'(i)}, 1, 1'b1, 1'(i));
         send_beat({24'hA5A5A5, 8'(i)}, 4'h1, 1'b1, 1'(i), hs, bsy);
         idle_in();
         drain();
         check("wrap_pkt_count", 64'(pkt_count), 64'((i + 1) % 16));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
